shift_seq_ctrl: RTL
===================

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  request present; a, op, amt are valid.
REQ-005 in_ready  output  1  controller can accept a request (state IDLE).
REQ-006 a  input  8  operand.
REQ-007 op  input  2  00 right shift, 01 left shift, 10 right rotate, 11 left rotate.
REQ-008 amt  input  3  step count, 0..7.
REQ-009 abort  input  1  synchronous cancel of any operation in progress.
REQ-010 out_valid  output  1  result is valid (state DONE).
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 result  output  8  registered operand/result.
REQ-013 busy  output  1  high in SHIFT or DONE.

Function
REQ-014 The module SHALL have an FSM with three states: IDLE, SHIFT and DONE; in_ready=(IDLE), out_valid=(DONE), busy=!(IDLE), all decoded from the state register.
REQ-015 Accept SHALL occur on an edge where state=IDLE, in_valid=1 and abort=0: result<=a, op and amt latched, cnt<=amt, next state SHIFT.
REQ-016 In SHIFT with cnt!=0, each edge SHALL apply exactly one 1-bit step to result per latched op and SHALL decrement cnt.
- 00: {0,r[7:1]}
- 01: {r[6:0],0}
- 10: {r[0],r[7:1]}
- 11: {r[6:0],r[7]}
REQ-017 In SHIFT with cnt=0, the next edge SHALL move to DONE with result unchanged.
REQ-018 Latency: counting the accept edge as edge 1, out_valid SHALL rise after edge amt+2; amt=0 gives out_valid after edge 2 with result=a.
REQ-019 In DONE, result and out_valid SHALL hold until an edge with out_ready=1, which SHALL return to IDLE; no new request is accepted on that edge.
REQ-020 in_valid while not IDLE SHALL be ignored; a, op and amt changes after accept SHALL not affect the operation in flight.
REQ-021 abort=1 on any edge SHALL force IDLE and clear cnt; result SHALL retain its last value.
REQ-022 abort SHALL take priority over accept, step and out_ready on the same edge.
REQ-023 cnt SHALL be 3 bits and SHALL never wrap below 0; amt=7 with a rotate op SHALL equal a single rotate in the opposite direction.
REQ-024 Requests MAY be issued back-to-back: in_valid held high SHALL be accepted on the first edge after the return to IDLE.

Reset
REQ-025 rst=0 SHALL immediately, without a clock, set state=IDLE, result=8'h00, cnt=0, latched op=00, latched amt=0; hence in_ready=1, out_valid=0, busy=0.
REQ-026 Reset asserted mid-operation SHALL discard the operation with no out_valid pulse; after rst rises, the first accept SHALL behave as from power-up.

Verification
REQ-027 a=8'hB1, op=00, amt=3 -> out_valid after edge 5, result=8'h16.
REQ-028 a=8'hB1, op=01, amt=2 -> out_valid after edge 4, result=8'hC4; hold out_ready=0 for 3 cycles -> result and out_valid stable.
REQ-029 a=8'hB1, op=10, amt=3 -> 8'h36; a=8'hB1, op=11, amt=7 -> 8'hD8; a=8'hB1, any op, amt=0 -> 8'hB1 after edge 2.
REQ-030 Abort asserted on the 2nd SHIFT edge of op=01, amt=5 -> IDLE next cycle, no out_valid, in_ready=1; a following request completes correctly.
REQ-031 rst pulsed low mid-SHIFT -> outputs reset asynchronously (result=8'h00, busy=0); in_valid held high with a changing during SHIFT -> ignored, result unaffected.
REQ-032 Two back-to-back requests with in_valid constant and out_ready=1 -> two results in order, one IDLE cycle between them.

Source files
------------

// File: rtl/shift_seq_ctrl_if.sv
// Request/result handshake bundle for shift_seq_ctrl.
// The master drives requests and consumes results; the slave is the controller.
interface shift_seq_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [1:0] op;
    logic [2:0] amt;
    logic       abort;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       busy;

    modport master (
        output in_valid,
        output a,
        output op,
        output amt,
        output abort,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  a,
        input  op,
        input  amt,
        input  abort,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output busy
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift/rotate sequencer: accepts an operand, applies one 1-bit
// shift or rotate per cycle for amt cycles, then presents the result until it
// is taken. abort cancels any operation; result keeps its last value.
module shift_seq_ctrl (
    input  logic                   clk,
    input  logic                   rst,
    shift_seq_ctrl_if.slave        bus
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam logic [1:0] OpShr = 2'b00;
    localparam logic [1:0] OpShl = 2'b01;
    localparam logic [1:0] OpRor = 2'b10;
    localparam logic [1:0] OpRol = 2'b11;

    state_e     state_q;
    logic [7:0] result_q;
    logic [2:0] cnt_q;
    logic [1:0] op_q;
    logic [2:0] amt_q;

    // One 1-bit step of the latched operation.
    function automatic logic [7:0] step(input logic [7:0] r, input logic [1:0] o);
        logic [7:0] s;
        unique case (o)
            OpShr:   s = {1'b0, r[7:1]};
            OpShl:   s = {r[6:0], 1'b0};
            OpRor:   s = {r[0], r[7:1]};
            OpRol:   s = {r[6:0], r[7]};
            default: s = r;
        endcase
        return s;
    endfunction

    // Sequencer FSM; abort overrides accept, step and result hand-off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            result_q <= 8'h00;
            cnt_q    <= 3'd0;
            op_q     <= OpShr;
            amt_q    <= 3'd0;
        end else if (bus.abort) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        result_q <= bus.a;
                        op_q     <= bus.op;
                        amt_q    <= bus.amt;
                        cnt_q    <= bus.amt;
                        state_q  <= StShift;
                    end
                end
                StShift: begin
                    // cnt only decrements when non-zero, so it never wraps.
                    if (cnt_q != 3'd0) begin
                        result_q <= step(result_q, op_q);
                        cnt_q    <= cnt_q - 3'd1;
                    end else begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= 3'd0;
                end
            endcase
        end
    end

    // Status flags decode straight from the state register so reset clears them
    // without waiting for a clock.
    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.result    = result_q;

    // Remaining steps can never exceed the step count captured at accept.
    cnt_bounded_a : assert property (
        @(posedge clk) disable iff (!rst) (state_q == StShift) |-> (cnt_q <= amt_q)
    );

    // The state register only ever holds one of the three encoded states.
    state_legal_a : assert property (
        @(posedge clk) disable iff (!rst)
        (state_q == StIdle) || (state_q == StShift) || (state_q == StDone)
    );

endmodule
